mak8_dmem_arbiter: RTL
======================

// Module: mak8_dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipelined CPU execute stage and a debug/loader
//  requester. The CPU has fixed priority, bounded by a starvation counter that forces one debug slot.
//  The debug port may lock the memory for a bounded burst.
//  Sits between the execute stage memory controls and the data_memory instance. CPU stalls via cpu_stall.
// PARAMETERS
//  ADDR_WIDTH    8  memory address width
//  DATA_WIDTH    8  memory data width
//  STARVE_LIMIT  4  consecutive losing debug cycles before a forced debug grant (>=2)
//  MAX_BURST     8  maximum consecutive debug grants under dbg_lock (>=1)
// PORTS
//  clk         in   1           system clock; single clock domain
//  rst         in   1           reset, asynchronous, active-high
//  cpu_req     in   1           CPU memory access request (execute stage, valid & mem_read|mem_write)
//  cpu_we      in   1           1 = write, 0 = read
//  cpu_addr    in   ADDR_WIDTH  CPU address
//  cpu_wdata   in   DATA_WIDTH  CPU write data
//  cpu_gnt     out  1           CPU access issued this cycle
//  cpu_stall   out  1           cpu_req & ~cpu_gnt; holds the pipeline
//  cpu_rvalid  out  1           CPU read data valid (cycle after granted read)
//  cpu_rdata   out  DATA_WIDTH  CPU read data
//  dbg_req     in   1           debug/loader request
//  dbg_we      in   1           1 = write, 0 = read
//  dbg_lock    in   1           request to hold the memory for consecutive debug beats
//  dbg_addr    in   ADDR_WIDTH  debug address
//  dbg_wdata   in   DATA_WIDTH  debug write data
//  dbg_gnt     out  1           debug access issued this cycle
//  dbg_rvalid  out  1           debug read data valid
//  dbg_rdata   out  DATA_WIDTH  debug read data
//  mem_read    out  1           to data_memory
//  mem_write   out  1           to data_memory
//  mem_addr    out  ADDR_WIDTH  to data_memory
//  mem_wdata   out  DATA_WIDTH  to data_memory
//  mem_rdata   in   DATA_WIDTH  from data_memory; valid 1 cycle after mem_read
// BEHAVIOUR
//  - Grants are combinational from requests and the registered state. At most one of cpu_gnt and dbg_gnt is high.
//    A grant is never issued without its req.
//  - mem_* are muxed from the granted port. mem_read = gnt & ~we; mem_write = gnt & we. With no grant, all mem_* are 0.
//  - Read return: an owner flag is registered on a granted read. Next cycle the owner's rvalid = 1 and its
//    rdata = mem_rdata. The registered rdata holds its last value otherwise. Latency is exactly 1 cycle, back-to-back allowed.
//  - starve_cnt (0..STARVE_LIMIT-1): increments when dbg_req & ~dbg_gnt. Clears on dbg_gnt or ~dbg_req.
//  - burst_cnt (1..MAX_BURST): counts debug grants in ARB_BURST.
//  - FSM:
//    ARB_CPU:   cpu_req wins, else dbg_req wins.
//               dbg granted & dbg_lock -> ARB_BURST (burst_cnt=1).
//               dbg loses & starve_cnt==STARVE_LIMIT-1 -> ARB_FORCE.
//    ARB_FORCE: dbg_req wins, else cpu_req wins.
//               dbg granted & dbg_lock -> ARB_BURST (burst_cnt=1); otherwise -> ARB_CPU.
//    ARB_BURST: dbg_req & dbg_lock -> dbg wins, burst_cnt++.
//               Otherwise arbitrate as ARB_CPU and -> ARB_CPU.
//               The grant that makes burst_cnt==MAX_BURST is the last burst grant -> ARB_CPU.
//  - Simultaneous events: in ARB_CPU the CPU always wins ties.
//    A forced slot is consumed by one debug grant, or abandoned if dbg_req drops.
//  - Reset values: state=ARB_CPU, starve_cnt=0, burst_cnt=0, owner flag clear.
//    All gnt/rvalid/mem_read/mem_write = 0, rdata = 0.
//  - Reset mid-operation: a pending read return is dropped (no rvalid after rst), and any burst is aborted.
//  - Requesters hold req/we/addr/wdata stable until granted.
// STRUCTURE
//  - Shared package mak8_arb_pkg: typedef enum logic [1:0] {ARB_CPU, ARB_FORCE, ARB_BURST} arb_state_t.
//    Port-index constants PORT_CPU=0, PORT_DBG=1.
//  - Single module, no sub-module. Grant logic is one always_comb; state, counters and the return
//    register are one always_ff each.
// TESTING
//  1. cpu_req read addr 0x10 (mem holds 0x5A), no dbg -> cpu_gnt=1, mem_read=1, mem_addr=0x10.
//     Next cycle cpu_rvalid=1, cpu_rdata=0x5A.
//  2. cpu_req held continuously with dbg_req write 0x20<-0x33, STARVE_LIMIT=4 -> dbg loses cycles 0-3.
//     Cycle 4: dbg_gnt=1, cpu_stall=1, mem_write=1. Cycle 5: cpu_gnt=1.
//  3. dbg_req+dbg_lock reads 0x00.., no cpu_req, MAX_BURST=8 -> 8 consecutive dbg_gnt and 8 dbg_rvalid.
//     Then ARB_CPU; a cpu_req raised at beat 3 is granted only after beat 8.
//  4. Same cycle cpu_req & dbg_req in ARB_CPU -> cpu_gnt=1, dbg_gnt=0, starve_cnt=1.
//     dbg_req dropped next cycle -> starve_cnt=0.
//  5. rst asserted the cycle after a granted dbg read -> dbg_rvalid stays 0, all outputs 0.
//     After release, the first cpu_req is granted immediately.
//  6. Alternating cpu read/write every cycle -> gnt every cycle, never cpu_gnt&dbg_gnt, rvalid only after reads.

Source files
------------

// File: rtl/mak8_arb_pkg.sv
// Shared types and constants for the mak8 data-memory arbiter.
package mak8_arb_pkg;

   typedef enum logic [1:0] {
      ARB_CPU   = 2'd0,
      ARB_FORCE = 2'd1,
      ARB_BURST = 2'd2
   } arb_state_t;

   localparam int unsigned PORT_CPU = 0;
   localparam int unsigned PORT_DBG = 1;

endpackage

// File: rtl/mak8_dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU execute stage and a debug/loader port:
// CPU priority, a starvation-forced debug slot, and bounded locked debug bursts.
module mak8_dmem_arbiter
   import mak8_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned MAX_BURST    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_stall,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic                  dbg_lock,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int unsigned SW = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   arb_state_t            state_q, state_d;
   logic [SW-1:0]         starve_q, starve_d;
   logic [BW-1:0]         burst_q, burst_d;
   logic                  rd_pend_q;
   logic                  rd_owner_q;
   logic [DATA_WIDTH-1:0] cpu_rdata_q;
   logic [DATA_WIDTH-1:0] dbg_rdata_q;
   logic                  dbg_lose;

   // Grant selection and next-state/counter computation
   always_comb begin
      cpu_gnt  = 1'b0;
      dbg_gnt  = 1'b0;
      state_d  = state_q;
      burst_d  = burst_q;
      starve_d = '0;
      dbg_lose = 1'b0;
      unique case (state_q)
         ARB_FORCE: begin
            dbg_gnt = dbg_req;
            cpu_gnt = cpu_req & ~dbg_req;
            state_d = ARB_CPU;
         end
         ARB_BURST: begin
            if (dbg_req && dbg_lock) begin
               dbg_gnt = 1'b1;
               burst_d = burst_q + BW'(1);
               state_d = (burst_d == BW'(MAX_BURST)) ? ARB_CPU : ARB_BURST;
            end else begin
               cpu_gnt = cpu_req;
               dbg_gnt = dbg_req & ~cpu_req;
               state_d = ARB_CPU;
            end
         end
         default: begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req & ~cpu_req;
         end
      endcase
      // Nothing may reach the memory while reset is held
      if (rst) begin
         cpu_gnt = 1'b0;
         dbg_gnt = 1'b0;
      end
      dbg_lose = dbg_req & ~dbg_gnt;
      if (dbg_gnt && dbg_lock && (state_q != ARB_BURST) && (MAX_BURST > 1)) begin
         state_d = ARB_BURST;
         burst_d = BW'(1);
      end else if (dbg_lose && (starve_q == SW'(STARVE_LIMIT - 1))) begin
         state_d = ARB_FORCE;
      end
      if (dbg_lose && (starve_q != SW'(STARVE_LIMIT - 1))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;
   assign mem_read  = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);
   assign mem_write = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
   assign mem_addr  = cpu_gnt ? cpu_addr  : (dbg_gnt ? dbg_addr  : '0);
   assign mem_wdata = cpu_gnt ? cpu_wdata : (dbg_gnt ? dbg_wdata : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ARB_CPU;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
         burst_q  <= '0;
      end else begin
         starve_q <= starve_d;
         burst_q  <= burst_d;
      end
   end

   // Read return tracking; each port's data register keeps its last returned value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend_q   <= 1'b0;
         rd_owner_q  <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         rd_pend_q  <= mem_read;
         rd_owner_q <= dbg_gnt;
         if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
         if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
      end
   end

   assign cpu_rvalid = rd_pend_q & (rd_owner_q == 1'(PORT_CPU));
   assign dbg_rvalid = rd_pend_q & (rd_owner_q == 1'(PORT_DBG));
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

endmodule
